// File: rtl/conway_pkg.sv
// conway_pkg: shared grid constants, ui_in bit positions and the row type.
package conway_pkg;
    localparam int GRID_N = 8;
    localparam int ROW_AW = 3;
    localparam int UI_WR = 3;
    localparam int UI_STEP = 4;
    localparam int UI_RUN = 5;
    localparam int UI_CLR = 6;
    typedef logic [GRID_N-1:0] row_t;
endpackage

// File: rtl/conway_life_core_if.sv
// conway_life_core_if: 8-in/8-out/8-bidir pin bundle between host and life core.
interface conway_life_core_if;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;
    modport master (output ui_in, uio_in, input uo_out, uio_out, uio_oe);
    modport slave (input ui_in, uio_in, output uo_out, uio_out, uio_oe);
endinterface

// File: rtl/conway_cell_next.sv
// conway_cell_next: B3/S23 next state of one cell from its eight neighbours.
module conway_cell_next (
    input  logic [7:0] nbr,
    input  logic       self,
    output logic       next
);
    logic [3:0] n;
    always_comb begin
        n = 4'($countones(nbr));
        next = (n == 4'd3) | (self & (n == 4'd2));
    end
endmodule

// File: rtl/conway_life_core.sv
// conway_life_core: 8x8 toroidal Game of Life grid with host load, step/run and row readback.
module conway_life_core
    import conway_pkg::*;
(
    input logic clk,
    input logic rst,
    input logic ena,
    conway_life_core_if.slave pins
);
    row_t grid [GRID_N];
    row_t nxt [GRID_N];
    logic step_q;
    logic step_go;
    logic [ROW_AW-1:0] addr;
    assign addr = pins.ui_in[ROW_AW-1:0];
    assign step_go = pins.ui_in[UI_RUN] | (pins.ui_in[UI_STEP] & ~step_q);
    assign pins.uo_out = grid[addr];
    assign pins.uio_out = 8'h00;
    assign pins.uio_oe = 8'h00;
    // wrapped neighbour indices are constants, so the torus costs no logic
    for (genvar r = 0; r < GRID_N; r++) begin : g_row
        localparam int RU = (r + GRID_N - 1) % GRID_N;
        localparam int RD = (r + 1) % GRID_N;
        for (genvar c = 0; c < GRID_N; c++) begin : g_col
            localparam int CL = (c + GRID_N - 1) % GRID_N;
            localparam int CR = (c + 1) % GRID_N;
            conway_cell_next u_cell (
                .nbr({grid[RU][CL], grid[RU][c], grid[RU][CR], grid[r][CL],
                      grid[r][CR], grid[RD][CL], grid[RD][c], grid[RD][CR]}),
                .self(grid[r][c]),
                .next(nxt[r][c])
            );
        end
    end
    // edge detector keeps sampling while disabled so a held step never replays
    always_ff @(posedge clk) begin
        step_q <= rst ? 1'b0 : pins.ui_in[UI_STEP];
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            grid <= '{default: '0};
        end else if (ena) begin
            if (pins.ui_in[UI_CLR])
                grid <= '{default: '0};
            else if (pins.ui_in[UI_WR])
                grid[addr] <= pins.uio_in;
            else if (step_go)
                grid <= nxt;
        end
    end
endmodule

// File: tb/tb_conway_life_core.sv
// tb_conway_life_core: vector table plus hand sequences for patterns, priority and wrap.
module tb_conway_life_core;
    logic clk = 1'b0;
    logic rst;
    logic ena;
    int total = 0;
    int bad = 0;
    conway_life_core_if p ();
    conway_life_core dut (.clk(clk), .rst(rst), .ena(ena), .pins(p.slave));
    always #5 clk = ~clk;
    typedef struct {
        logic       en;
        logic [7:0] ui;
        logic [7:0] d;
        logic [7:0] exp;
        string      name;
    } vec_t;
    vec_t vecs [14];
    task automatic tick(input logic [7:0] ui, input logic [7:0] d);
        p.ui_in = ui;
        p.uio_in = d;
        @(posedge clk);
        #1;
    endtask
    task automatic wr(input int r, input logic [7:0] d);
        tick(8'h08 | 8'(r), d);
    endtask
    task automatic pulse();
        tick(8'h10, 8'h00);
        tick(8'h00, 8'h00);
    endtask
    task automatic check_grid(input string name, input logic [63:0] exp);
        for (int r = 0; r < 8; r++) begin
            p.ui_in = 8'(r);
            #1;
            total++;
            if (p.uo_out !== exp[r*8 +: 8]) begin
                bad++;
                $display("FAIL %s row%0d got=%h want=%h", name, r, p.uo_out, exp[r*8 +: 8]);
            end
        end
    endtask
    initial begin
        vecs[0]  = '{1'b1, 8'h0A, 8'hA5, 8'hA5, "write_r2"};
        vecs[1]  = '{1'b1, 8'h02, 8'h00, 8'hA5, "read_r2"};
        vecs[2]  = '{1'b0, 8'h0A, 8'hFF, 8'hA5, "ena0_write"};
        vecs[3]  = '{1'b1, 8'h4A, 8'hFF, 8'h00, "clr_beats_write"};
        vecs[4]  = '{1'b1, 8'h0D, 8'h3C, 8'h3C, "write_r5"};
        vecs[5]  = '{1'b1, 8'h1D, 8'h3C, 8'h3C, "write_beats_step"};
        vecs[6]  = '{1'b1, 8'h05, 8'h00, 8'h3C, "step_dropped"};
        vecs[7]  = '{1'b0, 8'h15, 8'h00, 8'h3C, "ena0_step"};
        vecs[8]  = '{1'b1, 8'h15, 8'h00, 8'h3C, "edge_seen_while_off"};
        vecs[9]  = '{1'b1, 8'h05, 8'h00, 8'h3C, "idle_r5"};
        vecs[10] = '{1'b1, 8'h15, 8'h00, 8'h18, "step_r5"};
        vecs[11] = '{1'b1, 8'h04, 8'h00, 8'h18, "born_r4"};
        vecs[12] = '{1'b1, 8'h40, 8'h00, 8'h00, "clear_r0"};
        vecs[13] = '{1'b1, 8'h04, 8'h00, 8'h00, "clear_r4"};
        rst = 1'b1;
        ena = 1'b1;
        p.ui_in = 8'h00;
        p.uio_in = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_grid("reset_initial", 64'h0);
        total++;
        if ({p.uio_out, p.uio_oe} !== 16'h0000) begin
            bad++;
            $display("FAIL uio_tie got=%h want=0000", {p.uio_out, p.uio_oe});
        end
        for (int r = 0; r < 8; r++) wr(r, 8'hFF);
        check_grid("all_ff", {8{8'hFF}});
        rst = 1'b1;
        tick(8'h00, 8'h00);
        rst = 1'b0;
        check_grid("reset_after_ff", 64'h0);
        for (int i = 0; i < 14; i++) begin
            ena = vecs[i].en;
            tick(vecs[i].ui, vecs[i].d);
            ena = 1'b1;
            total++;
            if (p.uo_out !== vecs[i].exp) begin
                bad++;
                $display("FAIL %s got=%h want=%h", vecs[i].name, p.uo_out, vecs[i].exp);
            end
        end
        tick(8'h40, 8'h00);
        wr(3, 8'h1C);
        pulse();
        check_grid("blinker_v", 64'h00_00_00_08_08_08_00_00);
        pulse();
        check_grid("blinker_h", 64'h00_00_00_00_1C_00_00_00);
        repeat (5) tick(8'h10, 8'h00);
        tick(8'h00, 8'h00);
        check_grid("blinker_held", 64'h00_00_00_08_08_08_00_00);
        tick(8'h40, 8'h00);
        wr(0, 8'h81);
        wr(7, 8'h81);
        repeat (10) pulse();
        check_grid("block_wrap", 64'h81_00_00_00_00_00_00_81);
        tick(8'h40, 8'h00);
        wr(1, 8'h04);
        wr(2, 8'h08);
        wr(3, 8'h0E);
        repeat (4) tick(8'h20, 8'h00);
        tick(8'h00, 8'h00);
        check_grid("glider_4", 64'h00_00_00_1C_10_08_00_00);
        repeat (28) tick(8'h20, 8'h00);
        tick(8'h00, 8'h00);
        check_grid("glider_32", 64'h00_00_00_00_0E_08_04_00);
        rst = 1'b1;
        tick(8'h20, 8'h00);
        rst = 1'b0;
        tick(8'h00, 8'h00);
        check_grid("reset_mid_run", 64'h0);
        wr(4, 8'h10);
        pulse();
        check_grid("lone_dies", 64'h0);
        repeat (5) tick(8'h20, 8'h00);
        tick(8'h00, 8'h00);
        check_grid("empty_run", 64'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
